// File: rtl/uart_tx_fifo_if.sv
// Core-side write port and UART_TX-side handshake of the transmit byte FIFO.
// slave: the FIFO itself; master: whatever drives writes and emulates UART_TX.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
);
  logic                  i_fWr;
  logic [DATA_W-1:0]     i_WrData;
  logic                  i_fFlush;
  logic                  o_fFull;
  logic                  o_fEmpty;
  logic [DEPTH_LOG2:0]   o_Count;
  logic                  o_fOverflow;
  logic                  o_fTx;
  logic [DATA_W-1:0]     o_TxData;
  logic                  i_fTxReady;
  logic                  i_fTxDone;

  modport slave (
    input  i_fWr, i_WrData, i_fFlush, i_fTxReady, i_fTxDone,
    output o_fFull, o_fEmpty, o_Count, o_fOverflow, o_fTx, o_TxData
  );

  modport master (
    output i_fWr, i_WrData, i_fFlush, i_fTxReady, i_fTxDone,
    input  o_fFull, o_fEmpty, o_Count, o_fOverflow, o_fTx, o_TxData
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding UART_TX: accepts one byte per clock, drains one frame at a
// time through the fTx / fReady / fDone handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input logic           Clk,
  input logic           Rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_q, tx_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  wr_ok;
  logic                  pop;

  // Fullness is judged on the registered count; flush overrides any write.
  always_comb begin
    wr_ok    = bus.i_fWr && !full_q && !bus.i_fFlush;
    pop      = (state_q == IDLE) && !empty_q && bus.i_fTxReady;
    ovf_d    = bus.i_fWr && full_q && !bus.i_fFlush;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A pop alongside a flush still sends the byte at the old read pointer.
    if (bus.i_fFlush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d   = SEND;
          tx_d      = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (bus.i_fTxDone) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.i_WrData;
  end

  assign bus.o_fFull     = full_q;
  assign bus.o_fEmpty    = empty_q;
  assign bus.o_Count     = count_q;
  assign bus.o_fOverflow = ovf_q;
  assign bus.o_fTx       = tx_q;
  assign bus.o_TxData    = tx_data_q;
endmodule
